// File: rtl/falling_piece_if.sv
// Signal bundle between the active-piece controller, its input sources and the
// settling stage that consumes the four cell coordinates.
interface falling_piece_if;
    logic       tick_fall;
    logic       btn_left;
    logic       btn_right;
    logic       btn_rot;
    logic       settle;
    logic [3:0] x1, x2, x3, x4;
    logic [4:0] y1, y2, y3, y4;
    logic [2:0] piece_type;
    logic [2:0] next_type;
    logic [1:0] rot;

    modport slave (
        input  tick_fall, btn_left, btn_right, btn_rot, settle,
        output x1, x2, x3, x4, y1, y2, y3, y4, piece_type, next_type, rot
    );

    modport master (
        output tick_fall, btn_left, btn_right, btn_rot, settle,
        input  x1, x2, x3, x4, y1, y2, y3, y4, piece_type, next_type, rot
    );
endinterface

// File: rtl/falling_piece.sv
// Active-piece controller: spawns, drops, shifts and rotates the single falling
// tetromino and presents its four absolute cells to the settling stage.
module falling_piece #(
    parameter int         SPAWN_X   = 3,
    parameter int         HOLDOFF   = 2,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input logic            clk,
    input logic            reset,
    falling_piece_if.slave pif
);
    // state | meaning
    // SPAWN | load a fresh piece from the preview at the spawn anchor
    // HOLD  | settle-time after a coordinate change; buttons dropped, ticks pended
    // FALL  | accept at most one action per cycle, checked against walls and floor
    typedef enum logic [1:0] {SPAWN, HOLD, FALL} state_t;

    localparam logic [2:0] SEED_TYPE = (LFSR_SEED[2:0] == 3'd7) ? 3'd0 : LFSR_SEED[2:0];

    // One nibble {dx, dy} per cell, cell 1 in the top nibble.
    function automatic logic [3:0][3:0] shape(input logic [2:0] t, input logic [1:0] r);
        logic [3:0][3:0] s;
        case ({t, r})
            5'b000_00: s = 16'h159D;
            5'b000_01: s = 16'h89AB;
            5'b000_10: s = 16'h26AE;
            5'b000_11: s = 16'h4567;
            5'b010_00: s = 16'h4159;
            5'b010_01: s = 16'h4596;
            5'b010_10: s = 16'h1596;
            5'b010_11: s = 16'h4156;
            5'b011_00: s = 16'h4815;
            5'b011_01: s = 16'h459A;
            5'b011_10: s = 16'h5926;
            5'b011_11: s = 16'h0156;
            5'b100_00: s = 16'h0459;
            5'b100_01: s = 16'h8596;
            5'b100_10: s = 16'h156A;
            5'b100_11: s = 16'h4152;
            5'b101_00: s = 16'h0159;
            5'b101_01: s = 16'h4856;
            5'b101_10: s = 16'h159A;
            5'b101_11: s = 16'h4526;
            5'b110_00: s = 16'h8159;
            5'b110_01: s = 16'h456A;
            5'b110_10: s = 16'h1592;
            5'b110_11: s = 16'h0456;
            default:   s = 16'h4859;
        endcase
        return s;
    endfunction

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            tick_pend_q, tick_pend_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic [2:0]      next_type_q, next_type_d;
    logic [2:0]      type_q, type_d;
    logic [4:0]      ax_q, ax_d;
    logic [4:0]      ay_q, ay_d;
    logic [1:0]      rot_q, rot_d;
    logic [3:0][3:0] x_q, x_d;
    logic [3:0][4:0] y_q, y_d;

    logic            gravity, button, load;
    logic [2:0]      cand_type;
    logic [4:0]      cand_ax, cand_ay;
    logic [1:0]      cand_rot;
    logic [3:0][3:0] cand_shape;
    logic [3:0][5:0] cx, cy;
    logic            cand_ok;

    always_comb begin
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        gravity     = pif.tick_fall | tick_pend_q;
        button      = pif.btn_rot | pif.btn_left | pif.btn_right;
        state_d     = state_q;
        cnt_d       = cnt_q;
        tick_pend_d = tick_pend_q;
        type_d      = type_q;
        ax_d        = ax_q;
        ay_d        = ay_q;
        rot_d       = rot_q;
        x_d         = x_q;
        y_d         = y_q;
        load        = 1'b0;

        // Reset and spawn share the candidate path so reset cells come from the table too.
        cand_type = type_q;
        cand_ax   = ax_q;
        cand_ay   = ay_q;
        cand_rot  = rot_q;
        if (reset || state_q == SPAWN) begin
            cand_type = reset ? SEED_TYPE : next_type_q;
            cand_ax   = 5'(SPAWN_X);
            cand_ay   = 5'd0;
            cand_rot  = 2'd0;
        end else if (pif.btn_rot) begin
            cand_rot = rot_q + 2'd1;
        end else if (pif.btn_left) begin
            cand_ax = ax_q - 5'd1;
        end else if (pif.btn_right) begin
            cand_ax = ax_q + 5'd1;
        end else if (gravity) begin
            cand_ay = ay_q + 5'd1;
        end

        cand_shape = shape(cand_type, cand_rot);
        cand_ok    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cx[k] = {cand_ax[4], cand_ax} + {4'b0, cand_shape[3-k][3:2]};
            cy[k] = {1'b0, cand_ay} + {4'b0, cand_shape[3-k][1:0]};
            if (cx[k][5] || cx[k] > 6'd9 || cy[k] > 6'd19) cand_ok = 1'b0;
        end

        case (state_q)
            SPAWN: begin
                load    = 1'b1;
                state_d = HOLD;
                cnt_d   = 4'd0;
            end
            HOLD: begin
                if (pif.tick_fall) tick_pend_d = 1'b1;
                if (cnt_q == 4'(HOLDOFF - 1)) begin
                    state_d = FALL;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            FALL: begin
                if (button) begin
                    if (pif.tick_fall) tick_pend_d = 1'b1;
                end else if (gravity) begin
                    tick_pend_d = 1'b0;
                end
                if ((button || gravity) && cand_ok) begin
                    load    = 1'b1;
                    state_d = HOLD;
                    cnt_d   = 4'd0;
                end
            end
            default: state_d = HOLD;
        endcase

        if (pif.settle && state_q != SPAWN) begin
            load        = 1'b0;
            state_d     = SPAWN;
            tick_pend_d = 1'b0;
        end

        if (reset) begin
            load        = 1'b1;
            state_d     = HOLD;
            cnt_d       = 4'd0;
            tick_pend_d = 1'b0;
            lfsr_d      = LFSR_SEED;
        end

        if (load) begin
            type_d = cand_type;
            ax_d   = cand_ax;
            ay_d   = cand_ay;
            rot_d  = cand_rot;
            for (int k = 0; k < 4; k++) begin
                x_d[k] = cx[k][3:0];
                y_d[k] = cy[k][4:0];
            end
        end

        next_type_d = (lfsr_d[2:0] == 3'd7) ? 3'd0 : lfsr_d[2:0];
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        tick_pend_q <= tick_pend_d;
        lfsr_q      <= lfsr_d;
        next_type_q <= next_type_d;
        type_q      <= type_d;
        ax_q        <= ax_d;
        ay_q        <= ay_d;
        rot_q       <= rot_d;
        x_q         <= x_d;
        y_q         <= y_d;
    end

    assign pif.x1         = x_q[0];
    assign pif.x2         = x_q[1];
    assign pif.x3         = x_q[2];
    assign pif.x4         = x_q[3];
    assign pif.y1         = y_q[0];
    assign pif.y2         = y_q[1];
    assign pif.y3         = y_q[2];
    assign pif.y4         = y_q[3];
    assign pif.piece_type = type_q;
    assign pif.next_type  = next_type_q;
    assign pif.rot        = rot_q;
endmodule
